// File: rtl/bank_fifo_wr_arb.sv
// Round-robin write-port arbiter for the bank FIFO: each grant owns exactly one
// bank of 2^(N-1) words, laid out as header, payload, then padding.
module bank_fifo_wr_arb #(
    parameter int          N       = 8,
    parameter int          R       = 2,
    parameter logic [15:0] PadWord = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req_valid,
    input  logic [16*R-1:0] req_data,
    input  logic [R-1:0]    req_last,
    output logic [R-1:0]    req_ready,
    output logic [R-1:0]    grant,
    output logic            busy,
    output logic            fifo_trigger,
    output logic [15:0]     fifo_data,
    input  logic            fifo_ok
);

    localparam int            CW      = N - 1;
    localparam logic [CW-1:0] CntLast = '1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;

    state_t        state;
    logic [1:0]    g;
    logic [1:0]    rr;
    logic [CW-1:0] cnt;
    logic [3:0]    cont;

    // Requester buses widened to four slots so a 2-bit grant index selects directly.
    logic [3:0]  valid4;
    logic [3:0]  last4;
    logic [63:0] data64;
    logic        cur_valid;
    logic        cur_last;
    logic [15:0] cur_data;

    assign valid4    = 4'(req_valid);
    assign last4     = 4'(req_last);
    assign data64    = 64'(req_data);
    assign cur_valid = valid4[g];
    assign cur_last  = last4[g];
    assign cur_data  = data64[{g, 4'b0000} +: 16];

    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;

    // First valid requester scanning upward from the one after the last grant.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick  = rr;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= R; k++) begin
            cand = 2'((int'(rr) + k) % R);
            if (!found && valid4[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_trigger = 1'b0;
        fifo_data    = '0;
        unique case (state)
            HDR: begin
                fifo_trigger = 1'b1;
                fifo_data    = {8'hB5, 5'b0, cont[g], g};
            end
            DATA: begin
                fifo_trigger = cur_valid;
                fifo_data    = cur_data;
            end
            PAD: begin
                fifo_trigger = 1'b1;
                fifo_data    = PadWord;
            end
            default: ;
        endcase
    end

    logic wr;
    assign wr   = fifo_trigger && fifo_ok;
    assign busy = (state != IDLE);

    for (genvar i = 0; i < R; i++) begin : g_req
        assign req_ready[i] = (state == DATA) && (g == 2'(i)) && fifo_ok;
        assign grant[i]     = (state != IDLE) && (g == 2'(i));
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            // Last-grant starts at the top index so the first scan begins at requester 0.
            rr    <= 2'(R - 1);
            cnt   <= '0;
            cont  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        g     <= pick;
                        rr    <= pick;
                        cnt   <= '0;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (wr) begin
                        cnt   <= CW'(1);
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (wr) begin
                        cnt <= cnt + CW'(1);
                        if (cur_last) begin
                            cont[g] <= 1'b0;
                            state   <= (cnt == CntLast) ? IDLE : PAD;
                        end else if (cnt == CntLast) begin
                            // Bank full mid-packet: the remainder follows in a later bank.
                            cont[g] <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                PAD: begin
                    if (wr) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CntLast) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_fifo_wr_arb.sv
// Scoreboard bench for bank_fifo_wr_arb with N=4 (8-word banks) and two requesters.
module tb_bank_fifo_wr_arb;

    localparam int N = 4;
    localparam int R = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [R-1:0]    drv_valid = '0;
    logic [R-1:0]    hold = '0;
    logic [R-1:0]    req_valid;
    logic [16*R-1:0] req_data = '0;
    logic [R-1:0]    req_last = '0;
    logic [R-1:0]    req_ready;
    logic [R-1:0]    grant;
    logic            busy;
    logic            fifo_trigger;
    logic [15:0]     fifo_data;
    logic            fifo_ok = 1'b1;

    assign req_valid = drv_valid & ~hold;

    bank_fifo_wr_arb #(.N(N), .R(R), .PadWord(16'hFFFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .fifo_trigger (fifo_trigger),
        .fifo_data    (fifo_data),
        .fifo_ok      (fifo_ok)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [16:0] src0[$];
    logic [16:0] src1[$];
    logic [17:0] exp_q[$];
    logic [R-1:0] acc = '0;
    logic [17:0] mon_exp;
    logic [16:0] dummy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: every FIFO write is compared against the next expected {grant, word}.
    always @(negedge clk) begin
        acc = req_valid & req_ready;
        if (!rst && fifo_trigger && fifo_ok) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got %h expected none at %0t", {grant, fifo_data}, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_write", 32'({grant, fifo_data}), 32'(mon_exp));
            end
        end
    end

    // Requester models: present queue heads, retire a word after each handshake.
    always @(posedge clk) begin
        #1;
        if (acc[0] && src0.size() > 0) dummy = src0.pop_front();
        if (acc[1] && src1.size() > 0) dummy = src1.pop_front();
        drv_valid[0] = (src0.size() > 0);
        drv_valid[1] = (src1.size() > 0);
        {req_last[0], req_data[15:0]}  = drv_valid[0] ? src0[0] : 17'h0;
        {req_last[1], req_data[31:16]} = drv_valid[1] ? src1[0] : 17'h0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expw(input logic [1:0] gnt, input logic [15:0] d);
        exp_q.push_back({gnt, d});
    endtask

    task automatic pads(input logic [1:0] gnt, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({gnt, 16'hFFFF});
    endtask

    task automatic wait_left(input string name, input int n);
        int t = 0;
        while (exp_q.size() > n && t < 400) begin
            tick();
            t++;
        end
        if (exp_q.size() > n) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d words pending expected %0d", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_drain(input string name);
        wait_left(name, 0);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_trigger"}, 32'(fifo_trigger), 32'd0);
        check({tag, "_data"},    32'(fifo_data),    32'd0);
        check({tag, "_ready"},   32'(req_ready),    32'd0);
        check({tag, "_grant"},   32'(grant),        32'd0);
        check({tag, "_busy"},    32'(busy),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Short packet, padded to the bank boundary.
        src0.push_back(17'h0_0001);
        src0.push_back(17'h0_0002);
        src0.push_back(17'h1_0003);
        expw(2'b01, 16'hB500);
        expw(2'b01, 16'h0001);
        expw(2'b01, 16'h0002);
        expw(2'b01, 16'h0003);
        pads(2'b01, 4);
        wait_drain("short_pkt");

        // Ten-word packet spans two banks; the second header carries the cont bit.
        for (int i = 0; i < 10; i++) src1.push_back({(i == 9), 16'h0100 + 16'(i)});
        src1.push_back(17'h1_0110);
        expw(2'b10, 16'hB501);
        for (int i = 0; i < 7; i++) expw(2'b10, 16'h0100 + 16'(i));
        expw(2'b10, 16'hB505);
        expw(2'b10, 16'h0107);
        expw(2'b10, 16'h0108);
        expw(2'b10, 16'h0109);
        pads(2'b10, 4);
        expw(2'b10, 16'hB501);
        expw(2'b10, 16'h0110);
        pads(2'b10, 6);
        wait_drain("span");

        // Both requesters loaded with two 7-word packets: banks alternate, no padding.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 7; i++) begin
                src0.push_back({(i == 6), 16'h0200 + 16'(16 * p + i)});
                src1.push_back({(i == 6), 16'h0300 + 16'(16 * p + i)});
            end
        end
        for (int p = 0; p < 2; p++) begin
            expw(2'b01, 16'hB500);
            for (int i = 0; i < 7; i++) expw(2'b01, 16'h0200 + 16'(16 * p + i));
            expw(2'b10, 16'hB501);
            for (int i = 0; i < 7; i++) expw(2'b10, 16'h0300 + 16'(16 * p + i));
        end
        wait_drain("round_robin");

        // FIFO backpressure for five cycles mid-payload.
        for (int i = 0; i < 5; i++) src0.push_back({(i == 4), 16'h0400 + 16'(i)});
        expw(2'b01, 16'hB500);
        for (int i = 0; i < 5; i++) expw(2'b01, 16'h0400 + 16'(i));
        pads(2'b01, 2);
        wait_left("bp_start", 5);
        fifo_ok = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_grant", 32'(grant), 32'(2'b01));
            tick();
        end
        fifo_ok = 1'b1;
        wait_drain("backpressure");

        // Requester goes quiet for four cycles: grant held, nothing written.
        for (int i = 0; i < 7; i++) src1.push_back({(i == 6), 16'h0500 + 16'(i)});
        expw(2'b10, 16'hB501);
        for (int i = 0; i < 7; i++) expw(2'b10, 16'h0500 + 16'(i));
        wait_left("stall_start", 5);
        hold[1] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_trigger", 32'(fifo_trigger), 32'd0);
            check("stall_grant", 32'(grant), 32'(2'b10));
            tick();
        end
        hold[1] = 1'b0;
        wait_drain("req_stall");

        // Reset in the middle of a continuation bank.
        for (int i = 0; i < 12; i++) src1.push_back({(i == 11), 16'h0600 + 16'(i)});
        expw(2'b10, 16'hB501);
        for (int i = 0; i < 7; i++) expw(2'b10, 16'h0600 + 16'(i));
        expw(2'b10, 16'hB505);
        expw(2'b10, 16'h0607);
        expw(2'b10, 16'h0608);
        wait_left("pre_reset", 0);
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        src0.delete();
        src1.delete();
        exp_q.delete();
        src0.push_back(17'h1_0800);
        src1.push_back(17'h1_0900);
        expw(2'b01, 16'hB500);
        expw(2'b01, 16'h0800);
        pads(2'b01, 6);
        expw(2'b10, 16'hB501);
        expw(2'b10, 16'h0900);
        pads(2'b10, 6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
